// File: rtl/smachine_control_unit.sv
// ---------------------------------------------------------------------------
// smachine_control_unit
//
// Multi-cycle control unit for a small 8-bit machine. Each instruction takes
// FETCH -> DECODE -> EXECUTE -> WRITEBACK, with FETCH stretched while the
// instruction memory withholds fetch_ack. A fetch that waits WAIT_LIMIT
// cycles is abandoned and the unit parks in HALT with timeout set.
//
// Parameters
//   PC_RESET   : pc value loaded on reset
//   WAIT_LIMIT : FETCH cycles without ack before timeout (1..255)
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : run permission (sampled in IDLE and at end of WRITEBACK)
//   fetch_ack, instr  : instruction memory handshake and data
//   fetch_req, pc     : fetch request and fetch address
//   alu_op            : ALU select, 7 = no operation
//   rd_sel, rs_sel    : register selects from the instruction register
//   imm               : immediate field from the instruction register
//   reg_we            : register-file write strobe (WRITEBACK only)
//   state             : current state code
//   count             : retired-instruction counter
//   halted, illegal,
//   timeout           : sticky status flags, cleared only by reset
// ---------------------------------------------------------------------------
module smachine_control_unit #(
  parameter logic [7:0] PC_RESET   = 8'h00,
  parameter int         WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fetch_ack,
  input  logic [15:0] instr,
  output logic        fetch_req,
  output logic [7:0]  pc,
  output logic [2:0]  alu_op,
  output logic [1:0]  rd_sel,
  output logic [1:0]  rs_sel,
  output logic [7:0]  imm,
  output logic        reg_we,
  output logic [2:0]  state,
  output logic [7:0]  count,
  output logic        halted,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [2:0] ALU_NONE  = 3'd7;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state_q;
  logic [15:0] ir;
  logic [7:0]  wait_cnt;
  logic [3:0]  opcode;
  logic        op_illegal;
  logic        op_writes;

  // Opcodes 1..7 map onto ALU selects 0..6; NOP, illegal and HALT select none.
  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      4'h1:    return 3'd0;
      4'h2:    return 3'd1;
      4'h3:    return 3'd2;
      4'h4:    return 3'd3;
      4'h5:    return 3'd4;
      4'h6:    return 3'd5;
      4'h7:    return 3'd6;
      default: return ALU_NONE;
    endcase
  endfunction

  assign opcode     = ir[15:12];
  assign op_illegal = (opcode >= 4'h8) && (opcode <= 4'hE);
  assign op_writes  = (opcode >= 4'h1) && (opcode <= 4'h7);

  assign rd_sel = ir[11:10];
  assign rs_sel = ir[9:8];
  assign imm    = ir[7:0];
  assign state  = state_q;

  // Strobes are registered and set on the edge that enters their state, so
  // fetch_req, alu_op and reg_we line up exactly with the state code.
  // NOTE: every register here uses non-blocking assignment so all updates in
  // one edge see the pre-edge values; blocking would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc        <= PC_RESET;
      ir        <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      fetch_req <= 1'b0;
      reg_we    <= 1'b0;
      alu_op    <= ALU_NONE;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= FETCH;
            fetch_req <= 1'b1;
            wait_cnt  <= '0;
          end
        end

        FETCH: begin
          if (fetch_ack) begin
            ir        <= instr;
            pc        <= pc + 8'd1;
            fetch_req <= 1'b0;
            state_q   <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            // This is the WAIT_LIMIT-th consecutive cycle without ack.
            timeout   <= 1'b1;
            fetch_req <= 1'b0;
            state_q   <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DECODE: begin
          if (opcode == 4'hF) begin
            halted  <= 1'b1;
            state_q <= HALT;
          end else begin
            if (op_illegal) illegal <= 1'b1;
            alu_op  <= alu_sel(opcode);
            state_q <= EXECUTE;
          end
        end

        EXECUTE: begin
          alu_op  <= ALU_NONE;
          reg_we  <= op_writes;
          state_q <= WRITEBACK;
        end

        WRITEBACK: begin
          reg_we <= 1'b0;
          count  <= count + 8'd1;
          if (enable) begin
            state_q   <= FETCH;
            fetch_req <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end

        HALT: begin
          // Absorbing: pc, count and flags hold; strobes are already low.
          fetch_req <= 1'b0;
          reg_we    <= 1'b0;
          alu_op    <= ALU_NONE;
        end

        default: begin
          // Unused codes 6 and 7 fall back to IDLE with strobes released.
          state_q   <= IDLE;
          fetch_req <= 1'b0;
          reg_we    <= 1'b0;
          alu_op    <= ALU_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smachine_control_unit.sv
// ---------------------------------------------------------------------------
// tb_smachine_control_unit
//
// Bench acts as the instruction memory. A behavioural model tracks the
// architectural results per instruction (pc, count, sticky flags, expected
// ALU select and write strobe) and the cycle-by-cycle phase is checked
// against the four-step instruction sequence plus any ack delay.
// ---------------------------------------------------------------------------
module tb_smachine_control_unit;

  localparam logic [7:0] PC_INIT = 8'hFE;
  localparam int         WLIMIT  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fetch_ack;
  logic [15:0] instr;
  logic        fetch_req;
  logic [7:0]  pc;
  logic [2:0]  alu_op;
  logic [1:0]  rd_sel;
  logic [1:0]  rs_sel;
  logic [7:0]  imm;
  logic        reg_we;
  logic [2:0]  state;
  logic [7:0]  count;
  logic        halted;
  logic        illegal;
  logic        timeout;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [7:0]  m_pc;
  logic [7:0]  m_count;
  logic        m_illegal;
  logic        m_halted;
  logic [15:0] m_ir;

  smachine_control_unit #(.PC_RESET(PC_INIT), .WAIT_LIMIT(WLIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fetch_ack(fetch_ack),
    .instr(instr), .fetch_req(fetch_req), .pc(pc), .alu_op(alu_op),
    .rd_sel(rd_sel), .rs_sel(rs_sel), .imm(imm), .reg_we(reg_we),
    .state(state), .count(count), .halted(halted), .illegal(illegal),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd7) return 3'(op - 4'd1);
    return 3'd7;
  endfunction

  function automatic logic [15:0] junk();
    logic [31:0] r;
    r = $urandom;
    return r[15:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'(PC_INIT));
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_strobes"}, {29'd0, fetch_req, reg_we, 1'b0}, 32'd0);
    check({tag, "_alu"}, 32'(alu_op), 32'd7);
    check({tag, "_flags"}, {29'd0, halted, illegal, timeout}, 32'd0);
    check({tag, "_ir"}, {20'd0, rd_sel, rs_sel, imm}, 32'd0);
  endtask

  // Asserts reset at the current instant, checks the asynchronous effect,
  // then releases it just after a rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    enable = 1'b0;
    fetch_ack = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
    m_pc = PC_INIT;
    m_count = 8'd0;
    m_illegal = 1'b0;
    m_halted = 1'b0;
    m_ir = 16'd0;
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH, IDLE or HALT.
  task automatic run_instr(input logic [15:0] word, input int delay, input logic en_next);
    logic [3:0] op;
    logic [2:0] nxt;
    op = word[15:12];
    for (int i = 0; i < delay; i++) begin
      fetch_ack = 1'b0;
      instr = junk();
      check("fetch_wait_state", 32'(state), 32'd1);
      check("fetch_wait_pc", 32'(pc), 32'(m_pc));
      check("fetch_wait_req", 32'(fetch_req), 32'd1);
      tick();
    end
    check("fetch_state", 32'(state), 32'd1);
    check("fetch_pc", 32'(pc), 32'(m_pc));
    check("fetch_strobes", {29'd0, fetch_req, reg_we, timeout}, 32'd4);
    fetch_ack = 1'b1;
    instr = word;
    tick();
    fetch_ack = 1'b0;
    instr = junk();
    m_pc = m_pc + 8'd1;
    m_ir = word;
    check("decode_state", 32'(state), 32'd2);
    check("decode_pc", 32'(pc), 32'(m_pc));
    check("decode_req", 32'(fetch_req), 32'd0);
    check("decode_alu", 32'(alu_op), 32'd7);
    if (op == 4'hF) begin
      tick();
      m_halted = 1'b1;
      check("halt_state", 32'(state), 32'd5);
      check("halt_flag", 32'(halted), 32'(m_halted));
      return;
    end
    if (op >= 4'h8) m_illegal = 1'b1;
    tick();
    enable = en_next;
    check("exec_state", 32'(state), 32'd3);
    check("exec_alu", 32'(alu_op), 32'(exp_alu(op)));
    check("exec_fields", {20'd0, rd_sel, rs_sel, imm}, {20'd0, word[11:0]});
    check("exec_illegal", 32'(illegal), 32'(m_illegal));
    check("exec_we", 32'(reg_we), 32'd0);
    tick();
    check("wb_state", 32'(state), 32'd4);
    check("wb_we", 32'(reg_we), 32'((op >= 4'h1) && (op <= 4'h7)));
    check("wb_count", 32'(count), 32'(m_count));
    tick();
    m_count = m_count + 8'd1;
    nxt = en_next ? 3'd1 : 3'd0;
    check("post_state", 32'(state), 32'(nxt));
    check("post_count", 32'(count), 32'(m_count));
    check("post_we", 32'(reg_we), 32'd0);
  endtask

  initial begin
    logic [15:0] prog [8];
    int          dly  [8];
    logic [3:0]  op;
    logic [31:0] r;
    logic        en;

    rst_n = 1'b0;
    enable = 1'b0;
    fetch_ack = 1'b0;
    instr = 16'd0;
    tick();
    tick();
    check_reset_outputs("power_on");
    do_reset("initial");
    tick();
    check("idle_hold", 32'(state), 32'd0);
    enable = 1'b1;
    tick();

    // Directed program: LDI r0,#5; LDI r1,#3; ADD..XOR. Second fetch waits 3.
    prog = '{16'h1005, 16'h1403, 16'h2100, 16'h3100, 16'h4000,
             16'h5100, 16'h6100, 16'h7100};
    dly  = '{0, 3, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) run_instr(prog[i], dly[i], 1'b1);
    check("prog_count", 32'(count), 32'd8);
    check("prog_pc", 32'(pc), 32'(8'(PC_INIT + 8'd8)));

    // Randomised instruction stream with ack delays and enable drops.
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      op = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 6))
                                      : 4'($urandom_range(0, 7));
      en = ($urandom_range(0, 4) != 0);
      run_instr({op, r[11:0]}, int'($urandom_range(0, 3)), en);
      if (!en) begin
        // Acks while idle must not disturb the instruction register or pc.
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          fetch_ack = 1'b1;
          instr = junk();
          tick();
          check("idle_state", 32'(state), 32'd0);
          check("idle_req", 32'(fetch_req), 32'd0);
          check("idle_ir", {pc, rd_sel, rs_sel, imm}, {m_pc, m_ir[11:0]});
        end
        fetch_ack = 1'b0;
        enable = 1'b1;
        tick();
        check("resume_state", 32'(state), 32'd1);
      end
    end

    // Reset while a fetch is outstanding.
    tick();
    check("pre_rst_fetch", 32'(state), 32'd1);
    #3;
    do_reset("rst_fetch");

    // Reset in WRITEBACK must cut the write strobe and the count update.
    enable = 1'b1;
    tick();
    fetch_ack = 1'b1;
    instr = 16'h1234;
    tick();
    fetch_ack = 1'b0;
    tick();
    tick();
    check("wb_before_rst", {29'd0, state}, 32'd4);
    check("wb_we_before_rst", 32'(reg_we), 32'd1);
    #2;
    do_reset("rst_wb");

    // Illegal opcode then HALT; HALT must absorb everything.
    enable = 1'b1;
    tick();
    run_instr(16'h9ABC, 0, 1'b1);
    run_instr(16'hF000, 1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      fetch_ack = $urandom_range(0, 1) == 1;
      instr = junk();
      tick();
      check("halt_hold_state", 32'(state), 32'd5);
      check("halt_hold_pc_cnt", {16'd0, pc, count}, {16'd0, m_pc, m_count});
      check("halt_hold_strobes", {28'd0, fetch_req, reg_we, alu_op == 3'd7, 1'b0}, 32'd2);
      check("halt_hold_flags", {29'd0, halted, illegal, timeout}, 32'd6);
    end

    // Fetch never acknowledged: HALT with timeout after exactly WLIMIT cycles.
    do_reset("rst_halt");
    enable = 1'b1;
    tick();
    for (int k = 0; k < WLIMIT; k++) begin
      check("to_wait_state", 32'(state), 32'd1);
      check("to_wait_flag", 32'(timeout), 32'd0);
      tick();
    end
    check("to_state", 32'(state), 32'd5);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_pc", 32'(pc), 32'(PC_INIT));
    tick();
    check("to_sticky", {29'd0, state, 1'b0} >> 1, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
